// File: rtl/console_uart_tx_pkg.sv
// console_uart_tx_pkg: shared data width, bus width and TX FSM encoding for the console UART
package console_uart_tx_pkg;

    localparam int XLEN           = 32;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/console_uart_tx_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through FIFO; a push into a full FIFO succeeds only alongside a pop
module byte_fifo
    import console_uart_tx_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign empty = level_q == '0;
    assign full  = level_q == (AW+1)'(DEPTH);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/console_uart_tx.sv
// console_uart_tx: buffers console write bytes and serialises them as contiguous 8N1 frames on uart_tx
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          console_we,
    input  logic [XLEN-1:0]               console_wdata,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    tx_state_e                      state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [2:0]                     bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]      shift_q, shift_d;
    logic                           tx_q, tx_d;
    logic                           overflow_q, overflow_d;
    logic                           pop, bit_done;
    logic                           fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0]      fifo_dout;
    logic                           unused_wdata;

    assign unused_wdata = ^console_wdata[XLEN-1:UART_DATA_BITS];

    byte_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (console_we),
        .pop   (pop),
        .din   (console_wdata[UART_DATA_BITS-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign uart_tx  = tx_q;
    assign overflow = overflow_q;
    assign tx_busy  = state_q != ST_IDLE || !fifo_empty;

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        bit_done   = cnt_q == CNT_MAX;
        cnt_d      = (state_q == ST_IDLE || bit_done) ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                shift_d = fifo_dout;
                state_d = ST_START;
            end
            ST_START: if (bit_done) begin
                state_d   = ST_DATA;
                bit_idx_d = '0;
            end
            ST_DATA: if (bit_done) begin
                bit_idx_d = bit_idx_q + 1'b1;
                state_d   = bit_idx_q == 3'd7 ? ST_STOP : ST_DATA;
            end
            ST_STOP: if (bit_done) begin
                // Reloading straight from STOP keeps back-to-back frames gapless
                pop     = !fifo_empty;
                shift_d = fifo_empty ? shift_q : fifo_dout;
                state_d = fifo_empty ? ST_IDLE : ST_START;
            end
            default: state_d = ST_IDLE;
        endcase
        tx_d       = state_d == ST_START ? 1'b0 :
                     state_d == ST_DATA  ? shift_d[bit_idx_d] : 1'b1;
        overflow_d = overflow_q || (console_we && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: directed stimulus against a frame-timeline model of the console UART transmitter
module tb_console_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        console_we = 1'b0;
    logic [31:0] console_wdata = '0;
    logic        uart_tx, tx_busy, overflow;
    logic [2:0]  fifo_level;

    int checks = 0;
    int passes = 0;

    console_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .console_we    (console_we),
        .console_wdata (console_wdata),
        .uart_tx       (uart_tx),
        .tx_busy       (tx_busy),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Model: queue of accepted bytes plus position t within the frame on the wire (-1 when idle)
    logic [7:0] q[$];
    logic [7:0] cur = '0;
    int         t = -1;
    bit         m_ovf = 0;
    bit         m_valid = 0;

    function automatic logic line_at(input logic [7:0] b, input int pos);
        if (pos < 0 || pos >= 9 * CPB) return 1'b1;
        if (pos < CPB) return 1'b0;
        return b[(pos - CPB) / CPB];
    endfunction

    always @(posedge clk) begin
        m_valid <= 1;
        if (reset) begin
            q.delete();
            t = -1;
            m_ovf = 0;
        end else begin
            if (t >= 0) t++;
            if ((t < 0 || t == FRAME) && q.size() > 0) begin
                cur = q.pop_front();
                t = 0;
            end else if (t == FRAME) t = -1;
            if (console_we) begin
                if (q.size() < DEPTH) q.push_back(console_wdata[7:0]);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) if (m_valid) begin
        chk("uart_tx", {31'b0, uart_tx}, {31'b0, line_at(cur, t)});
        chk("tx_busy", {31'b0, tx_busy}, {31'b0, t >= 0 || q.size() > 0});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("fifo_level", {29'b0, fifo_level}, q.size());
    end

    task automatic wr(input logic [31:0] d);
        console_we = 1'b1;
        console_wdata = d;
        @(posedge clk);
        #1 console_we = 1'b0;
    endtask

    // Samples the middle of each of the 10 bit cells; lead = edges to reach the first centre
    task automatic capture(input string nm, input logic [7:0] b, input int lead);
        logic [9:0] exp;
        exp = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            repeat (i == 0 ? lead : CPB) @(posedge clk);
            @(negedge clk);
            chk(nm, {31'b0, uart_tx}, {31'b0, exp[i]});
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_busy", {31'b0, tx_busy}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_level", {29'b0, fifo_level}, 32'd0);

        wr(32'h41);
        capture("frame_41", 8'h41, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after_41", {31'b0, tx_busy}, 32'd0);

        wr(32'hDEAD_BE5A);
        capture("frame_5a", 8'h5A, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);

        console_we = 1'b1;
        console_wdata = 32'h48;
        @(posedge clk);
        #1 console_wdata = 32'h69;
        @(posedge clk);
        #1 console_we = 1'b0;
        capture("frame_H", 8'h48, 1);
        capture("frame_i", 8'h69, CPB);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after_Hi", {31'b0, tx_busy}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            console_we = 1'b1;
            console_wdata = 32'h30 + i;
            @(posedge clk);
            #1;
        end
        console_we = 1'b0;
        @(negedge clk);
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        chk("ovf_level", {29'b0, fifo_level}, 32'd4);
        repeat (5 * FRAME) @(posedge clk);
        @(negedge clk);
        chk("ovf_idle_busy", {31'b0, tx_busy}, 32'd0);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);

        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            console_we = 1'b1;
            console_wdata = 32'hA0 + i;
            @(posedge clk);
            #1;
        end
        console_we = 1'b0;
        @(negedge clk);
        chk("mid_level", {29'b0, fifo_level}, 32'd2);
        repeat (15) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", {31'b0, uart_tx}, 32'd1);
        chk("mid_rst_level", {29'b0, fifo_level}, 32'd0);
        chk("mid_rst_ovf", {31'b0, overflow}, 32'd0);
        repeat (2 * FRAME) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_quiet_tx", {31'b0, uart_tx}, 32'd1);
        chk("mid_rst_quiet_busy", {31'b0, tx_busy}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
